lc_prefetch_full: RTL and testbench
===================================

# lc_prefetch_full

Per-bank local controller for the DRBE sample-memory ring. Owns a 256 x 32-bit sample memory, streams incoming samples into it, and emits delayed-tap read packets (`packet_out`) and prefetch packets (`prefetch_packet_out`) tagged with a destination address. Four instances form a ring:
- write, read and prefetch activity hand off between neighbours through boundary flags;
- a global controller starts reads and prefetches by pulsing valid with an address and a destination.

## Interface
- `N_sample`, 256: memory depth (samples).
- `datawidth`, 16: half-sample width; a memory word is 2*datawidth = 32 bits.
- `address_vector_width`, 8: destination address width.
- `id_width`, 4: controller id width (reserved, no function).
- `sample_address_width`, 8: memory address width.
- `packet_width`, 2*datawidth+address_vector_width = 40: packet is {dest[39:32], data[31:0]}.
- `size`, 2: reserved.
- Clock/reset: one clock; reset is synchronous and active-high (`CLK`, `reset`).
- `CLK` in 1: clock, rising edge.
- `reset` in 1: synchronous active-high reset.
- `init` in 1: reserved; ignored, may be X.
- `D` in 32: stream sample written when writing is active.
- `write_flag` in 1: start-write pulse (first bank).
- `input_write_boundary` in 1: write hand-off from previous bank.
- `write_boundary_next` out 1: write hand-off pulse to next bank.
- `from_glob_controller_valid` in 1: read start pulse.
- `from_glob_controller_delay` in 8: read start address.
- `from_glob_dest_addr` in 8: read destination.
- `input_boundary_flag` in 1, `prev_dest_address` in 8: read hand-off from previous bank.
- `boundary_next` out 1, `dest_address` out 8: read hand-off to next bank / current read dest.
- `packet_out` out 40: read packet, 0 when idle.
- `from_glob_prefetch_valid` in 1, `from_glob_prefetch_start` in 8, `from_glob_prefetch_stop` in 8, `from_glob_prefetch_dest` in 8: prefetch start.
- `input_prefetch_boundary_flag` in 1, `prefetch_next_stop_address` in 8, `prefetch_next_dest_addr` in 8: prefetch hand-off from the next-index bank.
- `prefetch_boundary_prev` out 1, `prefetch_stop_address` out 8, `prefetch_dest_addr` out 8: prefetch hand-off to the previous-index bank / current prefetch stop and dest.
- `prefetch_packet_out` out 40: prefetch packet, 0 when idle.
- `WEBM` in 1: maintenance-port write enable, active low.
- `DM` in 32: maintenance-port write data.
- `BWEBM` in 32: maintenance-port bit write enable, active low per bit.
- `ext_sample_address_M` in 8: maintenance-port address.

## Operation
- **Memory.** 256 x 32, not reset. Two read engines and one stream write per cycle.
  - Reads return pre-write (old) data when the read and write hit the same address in the same cycle.
  - Maintenance write: when WEBM=0, bits with BWEBM=0 of `mem[ext_sample_address_M]` take DM.
  - If the stream write hits the same address in the same cycle, the stream write wins.
- **Write engine.**
  - write_flag or input_write_boundary (either also restarts an active writer) writes D to address 0 that edge; wptr=1, active.
  - While active, each edge writes D to `mem[wptr]` and increments wptr.
  - The edge writing address 255 clears active and sets write_boundary_next=1 for exactly one cycle.
- **Read engine.**
  - On valid (wins over input_boundary_flag), the edge reads `mem[delay]`, sets rptr=delay+1, latches dest_address=from_glob_dest_addr, and becomes active.
  - On input_boundary_flag, the edge reads `mem[0]`, sets rptr=1, latches dest_address=prev_dest_address, and becomes active.
  - While active, each edge reads `mem[rptr]` and increments rptr.
  - Each read registers packet_out={dest_address, data}. Edges with no read register packet_out=0.
  - The edge reading address 255 clears active and sets boundary_next=1 for one cycle. dest_address holds its value until the next load.
  - A new valid while active restarts the engine.
- **Prefetch engine.** Same structure as the read engine, using start/stop/dest, with these differences:
  - Load latches prefetch_stop_address and prefetch_dest_addr.
  - Hand-off loads from input_prefetch_boundary_flag with address 0 and the prefetch_next_* values.
  - Reading address == stop ends the prefetch (stop inclusive); prefetch_packet_out returns to 0 afterwards.
  - Reading 255 with stop != 255 ends locally and pulses prefetch_boundary_prev for one cycle; stop/dest outputs hold.
  - start==stop yields exactly one packet.
- Read, prefetch and write engines are fully independent.

## Timing
- Reset: all outputs 0, all engines idle, pointers 0.
- Reset mid-operation aborts every engine on that edge; no hand-off pulse is produced.
- Packet latency: the packet for the load address appears after the loading edge, i.e. 1 cycle after valid or flag is sampled.
- Hand-off is seamless: neighbour's address 0 packet follows this bank's address 255 packet in the next cycle.
- Boundary pulses are registered and 1 cycle wide.

## Test plan
- **Write:** write_flag pulse with D=0x1000+i per cycle → `mem[i]`=0x1000+i for i=0..255; write_boundary_next high exactly one cycle, right after the address-255 write.
- **Read:** valid with delay=0x19, dest=0x08 → packet_out = {0x08, `mem[0x19]`}, {0x08, `mem[0x1A]`}, … {0x08, `mem[0xFF]`} on consecutive cycles. boundary_next pulses once, then packet_out=0.
- **Four-bank ring, read:** read handed from bank 2 → bank 3 emits {0x08, `mem3[0]`} in the cycle after bank 2's `mem[0xFF]` packet.
- **Prefetch:** start=0x50, stop=0x60, dest=0x6F → exactly 17 packets, addresses 0x50..0x60; no prefetch_boundary_prev.
- **Prefetch wrap:** start=0xFE, stop=0x01 → addresses 0xFE, 0xFF here; prefetch_boundary_prev pulse; the receiving bank emits addresses 0x00, 0x01 with dest kept.
- **Priority and reset:** valid and input_boundary_flag in the same cycle → the global valid's address is loaded. Reset asserted mid-read → packet_out=0 and boundary_next=0 from the next edge.

Source files
------------

// File: rtl/lc_prefetch_full.sv
// lc_prefetch_full: per-bank sample-memory controller with stream writer, delayed-tap reader and prefetcher.
// Ports: CLK/reset (sync, active-high); D/write_flag/input_write_boundary -> write_boundary_next (stream write);
//   from_glob_controller_*/input_boundary_flag/prev_dest_address -> packet_out/boundary_next/dest_address (read);
//   from_glob_prefetch_*/input_prefetch_boundary_flag/prefetch_next_* -> prefetch_packet_out/prefetch_boundary_prev/
//   prefetch_stop_address/prefetch_dest_addr (prefetch); WEBM/DM/BWEBM/ext_sample_address_M (maintenance write).
module lc_prefetch_full #(
   parameter int N_sample             = 256,
   parameter int datawidth            = 16,
   parameter int address_vector_width = 8,
   parameter int id_width             = 4,
   parameter int sample_address_width = 8,
   parameter int packet_width         = 2*datawidth+address_vector_width,
   parameter int size                 = 2
) (
   input  logic                            CLK,
   input  logic                            reset,
   input  logic                            init,
   input  logic [2*datawidth-1:0]          D,
   input  logic                            write_flag,
   input  logic                            input_write_boundary,
   output logic                            write_boundary_next,
   input  logic                            from_glob_controller_valid,
   input  logic [sample_address_width-1:0] from_glob_controller_delay,
   input  logic [address_vector_width-1:0] from_glob_dest_addr,
   input  logic                            input_boundary_flag,
   input  logic [address_vector_width-1:0] prev_dest_address,
   output logic                            boundary_next,
   output logic [address_vector_width-1:0] dest_address,
   output logic [packet_width-1:0]         packet_out,
   input  logic                            from_glob_prefetch_valid,
   input  logic [sample_address_width-1:0] from_glob_prefetch_start,
   input  logic [sample_address_width-1:0] from_glob_prefetch_stop,
   input  logic [address_vector_width-1:0] from_glob_prefetch_dest,
   input  logic                            input_prefetch_boundary_flag,
   input  logic [sample_address_width-1:0] prefetch_next_stop_address,
   input  logic [address_vector_width-1:0] prefetch_next_dest_addr,
   output logic                            prefetch_boundary_prev,
   output logic [sample_address_width-1:0] prefetch_stop_address,
   output logic [address_vector_width-1:0] prefetch_dest_addr,
   output logic [packet_width-1:0]         prefetch_packet_out,
   input  logic                            WEBM,
   input  logic [2*datawidth-1:0]          DM,
   input  logic [2*datawidth-1:0]          BWEBM,
   input  logic [sample_address_width-1:0] ext_sample_address_M
);
   localparam logic [sample_address_width-1:0] last = sample_address_width'(N_sample-1);
   logic [2*datawidth-1:0] mem [0:N_sample-1];
   logic w_active, r_active, p_active, w_en, r_en, p_en;
   logic [sample_address_width-1:0] wptr, rptr, pptr, w_addr, r_addr, p_addr, p_stop;
   logic [address_vector_width-1:0] r_dest, p_dest;
   logic unused;
   assign unused = init ^ (id_width > size);
   always_comb begin
      w_en   = !reset && (write_flag || input_write_boundary || w_active);
      w_addr = (write_flag || input_write_boundary) ? '0 : wptr;
      r_en   = from_glob_controller_valid || input_boundary_flag || r_active;
      r_addr = from_glob_controller_valid ? from_glob_controller_delay : input_boundary_flag ? '0 : rptr;
      r_dest = from_glob_controller_valid ? from_glob_dest_addr : input_boundary_flag ? prev_dest_address : dest_address;
      p_en   = from_glob_prefetch_valid || input_prefetch_boundary_flag || p_active;
      p_addr = from_glob_prefetch_valid ? from_glob_prefetch_start : input_prefetch_boundary_flag ? '0 : pptr;
      p_stop = from_glob_prefetch_valid ? from_glob_prefetch_stop :
               input_prefetch_boundary_flag ? prefetch_next_stop_address : prefetch_stop_address;
      p_dest = from_glob_prefetch_valid ? from_glob_prefetch_dest :
               input_prefetch_boundary_flag ? prefetch_next_dest_addr : prefetch_dest_addr;
   end
   // stream write is issued after the maintenance write so it wins on a shared address
   always_ff @(posedge CLK) begin
      if (!WEBM) mem[ext_sample_address_M] <= (mem[ext_sample_address_M] & BWEBM) | (DM & ~BWEBM);
      if (w_en) mem[w_addr] <= D;
   end
   always_ff @(posedge CLK) begin
      if (reset) begin
         w_active               <= 1'b0;
         r_active               <= 1'b0;
         p_active               <= 1'b0;
         wptr                   <= '0;
         rptr                   <= '0;
         pptr                   <= '0;
         write_boundary_next    <= 1'b0;
         boundary_next          <= 1'b0;
         dest_address           <= '0;
         packet_out             <= '0;
         prefetch_boundary_prev <= 1'b0;
         prefetch_stop_address  <= '0;
         prefetch_dest_addr     <= '0;
         prefetch_packet_out    <= '0;
      end else begin
         w_active               <= w_en && w_addr != last;
         wptr                   <= w_en ? w_addr + 1'b1 : wptr;
         write_boundary_next    <= w_en && w_addr == last;
         r_active               <= r_en && r_addr != last;
         rptr                   <= r_en ? r_addr + 1'b1 : rptr;
         boundary_next          <= r_en && r_addr == last;
         dest_address           <= r_dest;
         packet_out             <= r_en ? {r_dest, mem[r_addr]} : '0;
         // stop is inclusive; hitting the top address hands the rest to the neighbour
         p_active               <= p_en && p_addr != p_stop && p_addr != last;
         pptr                   <= p_en ? p_addr + 1'b1 : pptr;
         prefetch_boundary_prev <= p_en && p_addr == last && p_stop != last;
         prefetch_stop_address  <= p_stop;
         prefetch_dest_addr     <= p_dest;
         prefetch_packet_out    <= p_en ? {p_dest, mem[p_addr]} : '0;
      end
   end
endmodule

// File: tb/tb_lc_prefetch_full.sv
// tb_lc_prefetch_full: directed self-checking bench for lc_prefetch_full.
module tb_lc_prefetch_full;
   logic clk = 1'b0, reset, init, write_flag, input_write_boundary, write_boundary_next;
   logic [31:0] D, DM, BWEBM;
   logic from_glob_controller_valid, input_boundary_flag, boundary_next;
   logic [7:0] from_glob_controller_delay, from_glob_dest_addr, prev_dest_address, dest_address;
   logic [39:0] packet_out, prefetch_packet_out;
   logic from_glob_prefetch_valid, input_prefetch_boundary_flag, prefetch_boundary_prev, WEBM;
   logic [7:0] from_glob_prefetch_start, from_glob_prefetch_stop, from_glob_prefetch_dest;
   logic [7:0] prefetch_next_stop_address, prefetch_next_dest_addr, prefetch_stop_address, prefetch_dest_addr;
   logic [7:0] ext_sample_address_M;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   lc_prefetch_full dut (
      .CLK(clk), .reset(reset), .init(init), .D(D), .write_flag(write_flag),
      .input_write_boundary(input_write_boundary), .write_boundary_next(write_boundary_next),
      .from_glob_controller_valid(from_glob_controller_valid), .from_glob_controller_delay(from_glob_controller_delay),
      .from_glob_dest_addr(from_glob_dest_addr), .input_boundary_flag(input_boundary_flag),
      .prev_dest_address(prev_dest_address), .boundary_next(boundary_next), .dest_address(dest_address),
      .packet_out(packet_out), .from_glob_prefetch_valid(from_glob_prefetch_valid),
      .from_glob_prefetch_start(from_glob_prefetch_start), .from_glob_prefetch_stop(from_glob_prefetch_stop),
      .from_glob_prefetch_dest(from_glob_prefetch_dest), .input_prefetch_boundary_flag(input_prefetch_boundary_flag),
      .prefetch_next_stop_address(prefetch_next_stop_address), .prefetch_next_dest_addr(prefetch_next_dest_addr),
      .prefetch_boundary_prev(prefetch_boundary_prev), .prefetch_stop_address(prefetch_stop_address),
      .prefetch_dest_addr(prefetch_dest_addr), .prefetch_packet_out(prefetch_packet_out),
      .WEBM(WEBM), .DM(DM), .BWEBM(BWEBM), .ext_sample_address_M(ext_sample_address_M)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   initial begin
      reset = 1; init = 0; D = 0; write_flag = 0; input_write_boundary = 0;
      from_glob_controller_valid = 0; from_glob_controller_delay = 0; from_glob_dest_addr = 0;
      input_boundary_flag = 0; prev_dest_address = 0;
      from_glob_prefetch_valid = 0; from_glob_prefetch_start = 0; from_glob_prefetch_stop = 0;
      from_glob_prefetch_dest = 0; input_prefetch_boundary_flag = 0;
      prefetch_next_stop_address = 0; prefetch_next_dest_addr = 0;
      WEBM = 1; DM = 0; BWEBM = '1; ext_sample_address_M = 0;
      tick; tick;
      reset = 0;
      chk("rst_pkt", packet_out, 0);
      chk("rst_ppkt", prefetch_packet_out, 0);
      chk("rst_flags", {write_boundary_next, boundary_next, prefetch_boundary_prev}, 0);
      chk("rst_addrs", {dest_address, prefetch_stop_address, prefetch_dest_addr}, 0);
      // stream write 0x1000+i into every address
      write_flag = 1; D = 32'h1000;
      tick;
      write_flag = 0;
      chk("wbn_start", write_boundary_next, 0);
      for (int i = 1; i < 256; i++) begin
         D = 32'h1000 + i;
         tick;
         chk($sformatf("wbn_%0d", i), write_boundary_next, (i == 255));
      end
      D = 32'hDEAD;
      tick;
      chk("wbn_end", write_boundary_next, 0);
      // delayed-tap read from 0x19
      from_glob_controller_valid = 1; from_glob_controller_delay = 8'h19; from_glob_dest_addr = 8'h08;
      tick;
      from_glob_controller_valid = 0;
      chk("rd_first", packet_out, {8'h08, 32'h1019});
      chk("rd_dest", dest_address, 8'h08);
      for (int a = 8'h1A; a < 256; a++) begin
         tick;
         chk($sformatf("rd_%0h", a), packet_out, {8'h08, 32'h1000 + a});
         chk($sformatf("bn_%0h", a), boundary_next, (a == 255));
      end
      tick;
      chk("rd_idle", packet_out, 0);
      chk("bn_idle", boundary_next, 0);
      chk("rd_dest_hold", dest_address, 8'h08);
      // hand-off from previous bank
      input_boundary_flag = 1; prev_dest_address = 8'h33;
      tick;
      input_boundary_flag = 0;
      chk("ho_0", packet_out, {8'h33, 32'h1000});
      tick;
      chk("ho_1", packet_out, {8'h33, 32'h1001});
      // valid wins over boundary flag
      from_glob_controller_valid = 1; from_glob_controller_delay = 8'h80; from_glob_dest_addr = 8'h44;
      input_boundary_flag = 1; prev_dest_address = 8'h55;
      tick;
      from_glob_controller_valid = 0; input_boundary_flag = 0;
      chk("prio_0", packet_out, {8'h44, 32'h1080});
      tick;
      chk("prio_1", packet_out, {8'h44, 32'h1081});
      // reset mid-read
      reset = 1;
      tick;
      chk("mrst_pkt", packet_out, 0);
      chk("mrst_bn", boundary_next, 0);
      reset = 0;
      tick;
      chk("mrst_idle", packet_out, 0);
      // prefetch 0x50..0x60
      from_glob_prefetch_valid = 1; from_glob_prefetch_start = 8'h50;
      from_glob_prefetch_stop = 8'h60; from_glob_prefetch_dest = 8'h6F;
      tick;
      from_glob_prefetch_valid = 0;
      chk("pf_50", prefetch_packet_out, {8'h6F, 32'h1050});
      chk("pf_stop", prefetch_stop_address, 8'h60);
      for (int a = 8'h51; a <= 8'h60; a++) begin
         tick;
         chk($sformatf("pf_%0h", a), prefetch_packet_out, {8'h6F, 32'h1000 + a});
         chk($sformatf("pbp_%0h", a), prefetch_boundary_prev, 0);
      end
      tick;
      chk("pf_done", prefetch_packet_out, 0);
      chk("pf_done_pbp", prefetch_boundary_prev, 0);
      // prefetch wrapping past the top address
      from_glob_prefetch_valid = 1; from_glob_prefetch_start = 8'hFE;
      from_glob_prefetch_stop = 8'h01; from_glob_prefetch_dest = 8'h22;
      tick;
      from_glob_prefetch_valid = 0;
      chk("pw_fe", prefetch_packet_out, {8'h22, 32'h10FE});
      chk("pw_fe_pbp", prefetch_boundary_prev, 0);
      tick;
      chk("pw_ff", prefetch_packet_out, {8'h22, 32'h10FF});
      chk("pw_ff_pbp", prefetch_boundary_prev, 1);
      tick;
      chk("pw_idle", prefetch_packet_out, 0);
      chk("pw_idle_pbp", prefetch_boundary_prev, 0);
      chk("pw_hold", {prefetch_stop_address, prefetch_dest_addr}, {8'h01, 8'h22});
      // receiving side of the prefetch hand-off
      input_prefetch_boundary_flag = 1; prefetch_next_stop_address = 8'h01; prefetch_next_dest_addr = 8'h22;
      tick;
      input_prefetch_boundary_flag = 0;
      chk("pr_00", prefetch_packet_out, {8'h22, 32'h1000});
      tick;
      chk("pr_01", prefetch_packet_out, {8'h22, 32'h1001});
      tick;
      chk("pr_idle", prefetch_packet_out, 0);
      // start == stop gives one packet
      from_glob_prefetch_valid = 1; from_glob_prefetch_start = 8'h10;
      from_glob_prefetch_stop = 8'h10; from_glob_prefetch_dest = 8'h09;
      tick;
      from_glob_prefetch_valid = 0;
      chk("one_10", prefetch_packet_out, {8'h09, 32'h1010});
      tick;
      chk("one_idle", prefetch_packet_out, 0);
      // maintenance write with bit enables: upper half takes DM, lower keeps old data
      WEBM = 0; ext_sample_address_M = 8'h05; DM = 32'hABCD_1234; BWEBM = 32'h0000_FFFF;
      tick;
      WEBM = 1; BWEBM = '1;
      from_glob_controller_valid = 1; from_glob_controller_delay = 8'h05; from_glob_dest_addr = 8'h01;
      tick;
      from_glob_controller_valid = 0;
      chk("mnt_05", packet_out, {8'h01, 32'hABCD_1005});
      // stream write beats maintenance write; read sees old data on collision
      write_flag = 1; D = 32'h7777;
      WEBM = 0; ext_sample_address_M = 8'h00; DM = 32'h5555_5555; BWEBM = '0;
      from_glob_controller_valid = 1; from_glob_controller_delay = 8'h00; from_glob_dest_addr = 8'h02;
      tick;
      write_flag = 0; WEBM = 1; BWEBM = '1; from_glob_controller_valid = 0; D = 32'h8888;
      chk("col_old0", packet_out, {8'h02, 32'h1000});
      tick;
      chk("col_old1", packet_out, {8'h02, 32'h1001});
      from_glob_controller_valid = 1; from_glob_controller_delay = 8'h00; from_glob_dest_addr = 8'h03;
      tick;
      from_glob_controller_valid = 0;
      chk("col_win", packet_out, {8'h03, 32'h7777});
      tick;
      chk("col_new1", packet_out, {8'h03, 32'h8888});
      reset = 1;
      tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
